// File: rtl/mips_ex_bjp_redirect_pkg.sv
// Types and widths shared by the EX-stage branch redirect block, its interface and its bench.
`ifndef MIPS_DEFINES_SV
`include "mips_defines.sv"
`endif

package mips_ex_bjp_redirect_pkg;

   localparam int ADDR_WIDTH = `MIPS_ADDR_WIDTH;
   localparam int DATA_WIDTH = `MIPS_DATA_WIDTH;

   typedef enum logic {
      BJP_ST_IDLE  = `MIPS_BJP_ST_IDLE,
      BJP_ST_REDIR = `MIPS_BJP_ST_REDIR
   } bjp_state_e;

   typedef logic [ADDR_WIDTH-1:0] addr_t;
   typedef logic [DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/mips_ex_bjp_redirect_if.sv
// Redirect handshake from EX to IF: the master (EX) holds valid and pc until ready is seen.
interface mips_ex_bjp_redirect_if;
   import mips_ex_bjp_redirect_pkg::*;

   logic  if_redirect_valid;
   logic  if_redirect_ready;
   addr_t if_redirect_pc;

   modport master (
      output if_redirect_valid,
      output if_redirect_pc,
      input  if_redirect_ready
   );

   modport slave (
      input  if_redirect_valid,
      input  if_redirect_pc,
      output if_redirect_ready
   );
endinterface

// File: rtl/mips_defines.sv
// Shared MIPS core defines: datapath widths and the branch-redirect FSM encodings.
// Define MIPS_BJP_DELAY_SLOT_EN on the command line to build for an architectural delay slot.
`ifndef MIPS_DEFINES_SV
`define MIPS_DEFINES_SV

`ifndef MIPS_DATA_WIDTH
`define MIPS_DATA_WIDTH 32
`endif

`ifndef MIPS_ADDR_WIDTH
`define MIPS_ADDR_WIDTH 32
`endif

`define MIPS_BJP_ST_IDLE  1'b0
`define MIPS_BJP_ST_REDIR 1'b1

`endif

// File: rtl/mips_ex_bjp_target.sv
// PC-relative target adder: pc_incr + (word offset << 2), wrapping modulo the address width.
module mips_ex_bjp_target
   import mips_ex_bjp_redirect_pkg::*;
(
   input  addr_t pc_incr_i,
   input  data_t imm_i,
   output addr_t target_o
);

   // The top two offset bits fall off the end once scaled to bytes.
   logic unused_imm_bits;
   assign unused_imm_bits = ^imm_i[DATA_WIDTH-1:ADDR_WIDTH-2];

   assign target_o = pc_incr_i + {imm_i[ADDR_WIDTH-3:0], 2'b00};

endmodule

// File: rtl/mips_ex_bjp_redirect.sv
// EX-stage branch resolution: registers the taken target, requests an IF redirect and flushes.
// With MIPS_BJP_DELAY_SLOT_EN defined the delay slot in EX commits, so flush_exmem stays low.
module mips_ex_bjp_redirect
   import mips_ex_bjp_redirect_pkg::*;
#(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ex_bjp_vld,
   input  logic                 alu_bjp_cmp_res,
   input  addr_t                bjp_pc_incr,
   input  data_t                bjp_imm,
   mips_ex_bjp_redirect_if.master redir,
   output logic                 flush_ifid,
   output logic                 flush_idex,
   output logic                 flush_exmem,
   output logic [CNT_WIDTH-1:0] bjp_taken_cnt
);

   bjp_state_e           state_q, state_d;
   addr_t                pc_q, pc_d;
   addr_t                target;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 take;
   logic                 redirect_active;

   mips_ex_bjp_target u_target (
      .pc_incr_i (bjp_pc_incr),
      .imm_i     (bjp_imm),
      .target_o  (target)
   );

   assign take = ex_bjp_vld & alu_bjp_cmp_res;

   // NOTE: non-blocking assignments here so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BJP_ST_IDLE;
         pc_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   // NOTE: defaults first so no path through the case leaves a signal unassigned (no latch).
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      case (state_q)
         BJP_ST_IDLE: begin
            if (take) begin
               state_d = BJP_ST_REDIR;
               pc_d    = target;
               cnt_d   = cnt_q + 1'b1;
            end
         end
         BJP_ST_REDIR: begin
            // EX holds bubbles while a redirect is outstanding, so its inputs are ignored here.
            if (redir.if_redirect_ready) begin
               state_d = BJP_ST_IDLE;
            end
         end
         default: state_d = BJP_ST_IDLE;
      endcase
   end

   always_comb begin
      redirect_active         = (state_q == BJP_ST_REDIR);
      redir.if_redirect_valid = redirect_active;
      flush_ifid              = redirect_active;
      flush_idex              = redirect_active;
`ifdef MIPS_BJP_DELAY_SLOT_EN
      flush_exmem             = 1'b0;
`else
      flush_exmem             = redirect_active;
`endif
   end

   assign redir.if_redirect_pc = pc_q;
   assign bjp_taken_cnt        = cnt_q;

endmodule

// File: tb/tb_mips_ex_bjp_redirect.sv
// Directed bench for mips_ex_bjp_redirect: stimulus queues expected targets, a monitor checks them.
module tb_mips_ex_bjp_redirect;
   import mips_ex_bjp_redirect_pkg::*;

   localparam int CW = 16;
`ifdef MIPS_BJP_DELAY_SLOT_EN
   localparam logic EXP_EXMEM = 1'b0;
`else
   localparam logic EXP_EXMEM = 1'b1;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ex_bjp_vld = 1'b0;
   logic          alu_bjp_cmp_res = 1'b0;
   addr_t         bjp_pc_incr = '0;
   data_t         bjp_imm = '0;
   logic          flush_ifid, flush_idex, flush_exmem;
   logic [CW-1:0] bjp_taken_cnt;

   int            n_checks = 0;
   int            n_errors = 0;
   addr_t         exp_q[$];
   logic [CW-1:0] exp_cnt = '0;

   mips_ex_bjp_redirect_if bus ();

   mips_ex_bjp_redirect #(.CNT_WIDTH(CW)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .ex_bjp_vld      (ex_bjp_vld),
      .alu_bjp_cmp_res (alu_bjp_cmp_res),
      .bjp_pc_incr     (bjp_pc_incr),
      .bjp_imm         (bjp_imm),
      .redir           (bus),
      .flush_ifid      (flush_ifid),
      .flush_idex      (flush_idex),
      .flush_exmem     (flush_exmem),
      .bjp_taken_cnt   (bjp_taken_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // EX must hold bubbles while a redirect is outstanding.
   always @(negedge clk) begin
      if (rst_n && ex_bjp_vld && bus.if_redirect_valid)
         $error("ex_bjp_vld asserted while a redirect is outstanding");
   end

   // Monitor: every redirect cycle must show the oldest queued target and the flushes.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.if_redirect_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_redirect", {31'b0, bus.if_redirect_valid}, 32'd0);
            end else begin
               check("redirect_pc", bus.if_redirect_pc, exp_q[0]);
               check("flush_ifid_redir", {31'b0, flush_ifid}, 32'd1);
               check("flush_idex_redir", {31'b0, flush_idex}, 32'd1);
               check("flush_exmem_redir", {31'b0, flush_exmem}, {31'b0, EXP_EXMEM});
               if (bus.if_redirect_ready) void'(exp_q.pop_front());
            end
         end else begin
            check("flushes_idle", {29'b0, flush_ifid, flush_idex, flush_exmem}, 32'd0);
         end
      end
   end

   // One branch through EX; ready is held low for 'hold' redirect cycles before acceptance.
   task automatic branch(input addr_t pc, input data_t imm, input logic cmp, input int hold,
                         input addr_t exp_pc);
      @(posedge clk); #1;
      ex_bjp_vld           = 1'b1;
      alu_bjp_cmp_res      = cmp;
      bjp_pc_incr          = pc;
      bjp_imm              = imm;
      bus.if_redirect_ready = (hold == 0);
      if (cmp) begin
         exp_q.push_back(exp_pc);
         exp_cnt++;
      end
      @(posedge clk); #1;
      ex_bjp_vld      = 1'b0;
      alu_bjp_cmp_res = 1'b0;
      check("valid_n1", {31'b0, bus.if_redirect_valid}, {31'b0, cmp});
      if (cmp) begin
         for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check("valid_hold", {31'b0, bus.if_redirect_valid}, 32'd1);
            if (k == hold - 1) bus.if_redirect_ready = 1'b1;
         end
         @(posedge clk); #1;
      end
      check("valid_after", {31'b0, bus.if_redirect_valid}, 32'd0);
      check("taken_cnt", {16'b0, bjp_taken_cnt}, {16'b0, exp_cnt});
      bus.if_redirect_ready = 1'b0;
   endtask

   task automatic check_all_zero(input string name);
      check(name, {28'b0, bus.if_redirect_valid, flush_ifid, flush_idex, flush_exmem}, 32'd0);
      check({name, "_pc"}, bus.if_redirect_pc, 32'd0);
      check({name, "_cnt"}, {16'b0, bjp_taken_cnt}, 32'd0);
   endtask

   initial begin
      bus.if_redirect_ready = 1'b0;

      // Reset state, then idle cycles.
      #12;
      check_all_zero("in_reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check_all_zero("after_idle");

      // Not-taken: no redirect, no flush, no count.
      branch(32'h0000_0104, 32'h0000_0010, 1'b0, 0, 32'h0);
      // Taken, accepted immediately.
      branch(32'h0000_0104, 32'h0000_0010, 1'b1, 0, 32'h0000_0144);
      // Taken, backward offset, ready low for 3 cycles.
      branch(32'h0000_0010, 32'hFFFF_FFFC, 1'b1, 3, 32'h0000_0000);
      // Large negative offset whose scaled value is truncated.
      branch(32'h0040_0000, 32'hFFFF_8000, 1'b1, 1, 32'h003E_0000);
      // Top offset bits are ignored.
      branch(32'h0000_2000, 32'hC000_0002, 1'b1, 0, 32'h0000_2008);

      // Wrap-around target, then asynchronous reset while the redirect is pending.
      @(posedge clk); #1;
      ex_bjp_vld      = 1'b1;
      alu_bjp_cmp_res = 1'b1;
      bjp_pc_incr     = 32'hFFFF_FFF8;
      bjp_imm         = 32'h0000_0004;
      exp_q.push_back(32'h0000_0008);
      exp_cnt++;
      @(posedge clk); #1;
      ex_bjp_vld      = 1'b0;
      alu_bjp_cmp_res = 1'b0;
      check("wrap_valid", {31'b0, bus.if_redirect_valid}, 32'd1);
      check("wrap_pc", bus.if_redirect_pc, 32'h0000_0008);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      exp_q.delete();
      exp_cnt = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Recovery after reset.
      branch(32'h0000_1000, 32'h0000_0001, 1'b1, 2, 32'h0000_1004);
      branch(32'h0000_1000, 32'h0000_0001, 1'b0, 0, 32'h0);

      repeat (2) @(posedge clk);
      #1;
      check("queue_empty", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
